waveform_sweep_sched: RTL and testbench
=======================================

WAVEFORM_SWEEP_SCHED -- requirements
Module: waveform_sweep_sched

Interface
REQ-001 SHALL have parameter freq_width, default 13, width of every frequency word.
REQ-002 SHALL have parameter dwell_width, default 20, width of the dwell-length word.
REQ-003 SHALL have port clk1  input  1  the single clock; every register is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a sweep; sampled in IDLE only.
REQ-006 SHALL have port stop  input  1  abort the active sweep.
REQ-007 SHALL have port hold  input  1  freeze the dwell counter.
REQ-008 SHALL have port f_start  input  freq_width  first frequency word, unsigned.
REQ-009 SHALL have port f_stop  input  freq_width  last allowed frequency word, unsigned.
REQ-010 SHALL have port f_step  input  freq_width  increment per dwell, unsigned.
REQ-011 SHALL have port dwell  input  dwell_width  cycles per frequency point; 0 is treated as 1.
REQ-012 SHALL have port wave_mask  input  4  waveforms to sweep; bit k enables waveform_sel=k.
REQ-013 SHALL have port loop  input  1  restart the sweep after the last waveform instead of finishing.
REQ-014 SHALL have port freq  output  freq_width  registered frequency word that drives the CORDIC generator.
REQ-015 SHALL have port waveform_sel  output  2  registered waveform select: 0 sine, 1 cosine, 2 triangle, 3 square.
REQ-016 SHALL have port busy  output  1  high while a sweep is active.
REQ-017 SHALL have port step_pulse  output  1  one-cycle pulse on every change of freq or waveform_sel.
REQ-018 SHALL have port done  output  1  one-cycle pulse on normal sweep completion.

Function
REQ-019 SHALL use two states, IDLE and DWELL, plus dwell counter cnt (dwell_width bits) and configuration registers.
REQ-020 SHALL, in IDLE with start=1 and stop=0 at a rising edge: capture f_start, f_stop, f_step, dwell, wave_mask and loop; set freq=f_start; set waveform_sel to the lowest set bit of the mask; set cnt=0 and busy=1; pulse step_pulse; enter DWELL.
REQ-021 SHALL treat a captured wave_mask of 0 as 4'b0001.
REQ-022 SHALL ignore input changes after capture until the next start.
REQ-023 SHALL, in DWELL with hold=0, increment cnt each cycle; with hold=1, keep cnt and all outputs unchanged.
REQ-024 SHALL apply the update of REQ-025 to REQ-028 at the edge where cnt equals D-1 (D is the captured dwell, forced to a minimum of 1) and hold=0; that same edge sets cnt=0.
REQ-025 SHALL, at that update, set freq to freq+f_step if f_step is non-zero and freq+f_step, computed at freq_width+1 bits, is at most f_stop; step_pulse then pulses.
REQ-026 SHALL otherwise, if a higher enabled waveform exists in the mask, set waveform_sel to the next higher enabled bit and freq to f_start, and pulse step_pulse.
REQ-027 SHALL otherwise, if loop=1, set waveform_sel to the lowest enabled bit and freq to f_start, and pulse step_pulse.
REQ-028 SHALL otherwise pulse done for one cycle, clear busy, enter IDLE, and hold freq and waveform_sel at their last values.
REQ-029 SHALL hold each frequency point on freq for exactly D cycles, excluding hold cycles.
REQ-030 SHALL, when f_start > f_stop or f_step = 0, produce one dwell at f_start per enabled waveform; the wider compare prevents any wrap-around.
REQ-031 SHALL, on stop=1 in DWELL, enter IDLE at the next edge with busy=0 and no done or step_pulse; stop takes priority over an update on the same edge; freq and waveform_sel hold.
REQ-032 SHALL ignore start while in DWELL; with start and stop both high in IDLE, it remains in IDLE.
REQ-033 SHALL ignore stop in IDLE.

Reset
REQ-034 SHALL, on reset=1 at any time including mid-sweep, immediately force IDLE, cnt=0, freq=0, waveform_sel=0, busy=0, step_pulse=0, done=0 and clear the configuration registers.
REQ-035 SHALL resume sampling start on the first rising edge after reset deasserts.

Verification
REQ-036 Linear sweep: f_start=100, f_stop=130, f_step=10, dwell=4, mask=0001, loop=0, start at edge E0 -> freq is 100 after E0, 110 after E4, 120 after E8, 130 after E12; done=1 and busy=0 after E16; freq holds 130.
REQ-037 Multi-waveform: f_start=10, f_stop=20, f_step=10, dwell=2, mask=1010 -> sequence (sel1,10),(sel1,20),(sel3,10),(sel3,20), each held 2 cycles, then done; 4 step_pulses.
REQ-038 Loop and stop: the REQ-036 config with loop=1 -> freq returns to 100 after E16 with no done; stop asserted at E20 -> busy=0 after E21 and freq holds.
REQ-039 Boundaries: dwell=0 gives a 1-cycle dwell; f_step=0 or f_start=200 > f_stop=100 gives a single point; f_start=8190, f_step=5, f_stop=8191 gives no wrap and ends after one dwell.
REQ-040 Hold and reset: hold=1 for 3 cycles mid-dwell stretches the point to D+3 cycles; reset asserted mid-sweep immediately gives freq=0 and busy=0; start after release begins a fresh sweep.

Source files
------------

// File: rtl/waveform_sweep_sched.sv
// Frequency/waveform sweep scheduler: steps a frequency word through a captured
// range for each enabled waveform, dwelling D cycles per point.
module waveform_sweep_sched #(
  parameter int freq_width  = 13,
  parameter int dwell_width = 20
) (
  input  logic                   clk1,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   hold,
  input  logic [freq_width-1:0]  f_start,
  input  logic [freq_width-1:0]  f_stop,
  input  logic [freq_width-1:0]  f_step,
  input  logic [dwell_width-1:0] dwell,
  input  logic [3:0]             wave_mask,
  input  logic                   loop,
  output logic [freq_width-1:0]  freq,
  output logic [1:0]             waveform_sel,
  output logic                   busy,
  output logic                   step_pulse,
  output logic                   done
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DWELL = 1'b1;
  localparam logic [dwell_width-1:0] CNT_ZERO = {dwell_width{1'b0}};
  localparam logic [dwell_width-1:0] CNT_ONE  = {{(dwell_width-1){1'b0}}, 1'b1};

  logic [0:0]             state_q, state_d;
  logic [dwell_width-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
  logic [freq_width-1:0]  freq_q, freq_d, fstart_q, fstart_d;
  logic [freq_width-1:0]  fstop_q, fstop_d, fstep_q, fstep_d;
  logic [3:0]             mask_q, mask_d;
  logic                   loop_q, loop_d;
  logic [1:0]             sel_q, sel_d;
  logic                   busy_q, busy_d, step_q, step_d, done_q, done_d;

  logic [3:0]             mask_in_s;
  logic [dwell_width-1:0] dwell_min_s;
  logic [freq_width:0]    sum_s;
  logic                   last_s, adv_s;
  logic [2:0]             next_s;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    lowest_bit = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) lowest_bit = k[1:0];
      else      lowest_bit = lowest_bit;
    end
  endfunction

  // Returns {found, index} of the lowest enabled bit strictly above s.
  function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] s);
    next_above = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (m[k] && (k > int'(s))) next_above = {1'b1, k[1:0]};
      else                       next_above = next_above;
    end
  endfunction

  assign mask_in_s   = (wave_mask == 4'b0000) ? 4'b0001 : wave_mask;
  assign dwell_min_s = (dwell_q == CNT_ZERO) ? CNT_ONE : dwell_q;
  assign last_s      = (cnt_q == (dwell_min_s - CNT_ONE));
  // One extra bit so a sum past the top of the range can never wrap below f_stop.
  assign sum_s       = {1'b0, freq_q} + {1'b0, fstep_q};
  assign adv_s       = (fstep_q != {freq_width{1'b0}}) && (sum_s <= {1'b0, fstop_q});
  assign next_s      = next_above(mask_q, sel_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    freq_d   = freq_q;
    fstart_d = fstart_q;
    fstop_d  = fstop_q;
    fstep_d  = fstep_q;
    mask_d   = mask_q;
    loop_d   = loop_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          fstart_d = f_start;
          fstop_d  = f_stop;
          fstep_d  = f_step;
          dwell_d  = dwell;
          mask_d   = mask_in_s;
          loop_d   = loop;
          freq_d   = f_start;
          sel_d    = lowest_bit(mask_in_s);
          cnt_d    = CNT_ZERO;
          busy_d   = 1'b1;
          step_d   = 1'b1;
          state_d  = S_DWELL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DWELL: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (hold) begin
          cnt_d = cnt_q;
        end else if (!last_s) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = CNT_ZERO;
          if (adv_s) begin
            freq_d = sum_s[freq_width-1:0];
            step_d = 1'b1;
          end else if (next_s[2]) begin
            sel_d  = next_s[1:0];
            freq_d = fstart_q;
            step_d = 1'b1;
          end else if (loop_q) begin
            sel_d  = lowest_bit(mask_q);
            freq_d = fstart_q;
            step_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      dwell_q  <= CNT_ZERO;
      freq_q   <= {freq_width{1'b0}};
      fstart_q <= {freq_width{1'b0}};
      fstop_q  <= {freq_width{1'b0}};
      fstep_q  <= {freq_width{1'b0}};
      mask_q   <= 4'b0000;
      loop_q   <= 1'b0;
      sel_q    <= 2'd0;
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      freq_q   <= freq_d;
      fstart_q <= fstart_d;
      fstop_q  <= fstop_d;
      fstep_q  <= fstep_d;
      mask_q   <= mask_d;
      loop_q   <= loop_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  assign freq         = freq_q;
  assign waveform_sel = sel_q;
  assign busy         = busy_q;
  assign step_pulse   = step_q;
  assign done         = done_q;

endmodule

// File: tb/tb_waveform_sweep_sched.sv
// Directed bench for waveform_sweep_sched with hand-computed expectations.
module tb_waveform_sweep_sched;
  localparam int FW = 13;
  localparam int DW = 20;

  logic          clk1 = 1'b0;
  logic          reset, start, stop, hold, loop;
  logic [FW-1:0] f_start, f_stop, f_step, freq;
  logic [DW-1:0] dwell;
  logic [3:0]    wave_mask;
  logic [1:0]    waveform_sel;
  logic          busy, step_pulse, done;

  int checks = 0;
  int errors = 0;
  int steps  = 0;

  waveform_sweep_sched #(.freq_width(FW), .dwell_width(DW)) dut (
    .clk1(clk1), .reset(reset), .start(start), .stop(stop), .hold(hold),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .wave_mask(wave_mask), .loop(loop), .freq(freq), .waveform_sel(waveform_sel),
    .busy(busy), .step_pulse(step_pulse), .done(done)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic cfg(input int fs, input int fe, input int st, input int dw,
                     input logic [3:0] m, input logic lp);
    f_start   = fs[FW-1:0];
    f_stop    = fe[FW-1:0];
    f_step    = st[FW-1:0];
    dwell     = dw[DW-1:0];
    wave_mask = m;
    loop      = lp;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
    cfg(0, 0, 0, 0, 4'b0000, 1'b0);
    #1;
    check("rst_freq", 32'(freq), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sel", 32'(waveform_sel), 0);
    check("rst_done_step", 32'({done, step_pulse}), 0);
    tick(2);
    #2 reset = 1'b0;

    // Linear sweep; inputs scrambled after capture must be ignored.
    cfg(100, 130, 10, 4, 4'b0001, 1'b0);
    do_start();
    cfg(7, 9, 99, 1, 4'b1000, 1'b1);
    check("lin_e0_freq", 32'(freq), 100);
    check("lin_e0_busy", 32'(busy), 1);
    check("lin_e0_step", 32'(step_pulse), 1);
    check("lin_e0_sel", 32'(waveform_sel), 0);
    tick(3);
    check("lin_e3_freq", 32'(freq), 100);
    check("lin_e3_step", 32'(step_pulse), 0);
    tick(1);
    check("lin_e4_freq", 32'(freq), 110);
    check("lin_e4_step", 32'(step_pulse), 1);
    tick(4);
    check("lin_e8_freq", 32'(freq), 120);
    tick(4);
    check("lin_e12_freq", 32'(freq), 130);
    tick(4);
    check("lin_e16_done", 32'(done), 1);
    check("lin_e16_busy", 32'(busy), 0);
    check("lin_e16_freq", 32'(freq), 130);
    check("lin_e16_step", 32'(step_pulse), 0);
    tick(1);
    check("lin_e17_done", 32'(done), 0);
    check("lin_e17_freq", 32'(freq), 130);

    // Multi-waveform sweep over mask 1010.
    cfg(10, 20, 10, 2, 4'b1010, 1'b0);
    do_start();
    steps = 32'(step_pulse);
    check("mw_e0", 32'({waveform_sel, freq}), 32'({2'd1, 13'd10}));
    tick(1);
    steps += 32'(step_pulse);
    check("mw_e1", 32'({waveform_sel, freq}), 32'({2'd1, 13'd10}));
    tick(1);
    steps += 32'(step_pulse);
    check("mw_e2", 32'({waveform_sel, freq}), 32'({2'd1, 13'd20}));
    tick(2);
    steps += 32'(step_pulse);
    check("mw_e4", 32'({waveform_sel, freq}), 32'({2'd3, 13'd10}));
    tick(1);
    steps += 32'(step_pulse);
    check("mw_e5", 32'({waveform_sel, freq}), 32'({2'd3, 13'd10}));
    tick(1);
    steps += 32'(step_pulse);
    check("mw_e6", 32'({waveform_sel, freq}), 32'({2'd3, 13'd20}));
    tick(1);
    steps += 32'(step_pulse);
    check("mw_e7_done", 32'(done), 0);
    tick(1);
    steps += 32'(step_pulse);
    check("mw_e8_done", 32'(done), 1);
    check("mw_steps", 32'(steps), 4);

    // Loop restart, then stop.
    cfg(100, 130, 10, 4, 4'b0001, 1'b1);
    do_start();
    tick(16);
    check("loop_e16_freq", 32'(freq), 100);
    check("loop_e16_done", 32'(done), 0);
    check("loop_e16_busy", 32'(busy), 1);
    check("loop_e16_step", 32'(step_pulse), 1);
    tick(4);
    check("loop_e20_freq", 32'(freq), 110);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_busy", 32'(busy), 0);
    check("stop_freq", 32'(freq), 110);
    check("stop_pulses", 32'({done, step_pulse}), 0);
    tick(2);
    check("stop_idle_busy", 32'(busy), 0);
    check("stop_idle_freq", 32'(freq), 110);

    // dwell=0 acts as a one-cycle dwell.
    cfg(5, 7, 1, 0, 4'b0001, 1'b0);
    do_start();
    check("d0_e0", 32'(freq), 5);
    tick(1);
    check("d0_e1", 32'(freq), 6);
    tick(1);
    check("d0_e2", 32'(freq), 7);
    tick(1);
    check("d0_e3_done", 32'({done, busy}), 32'({1'b1, 1'b0}));

    // Stop wins over an update on the same edge.
    do_start();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stopprio_freq", 32'(freq), 5);
    check("stopprio_flags", 32'({busy, done, step_pulse}), 0);

    // Zero step: single point.
    cfg(50, 100, 0, 1, 4'b0001, 1'b0);
    do_start();
    check("step0_e0", 32'({busy, freq}), 32'({1'b1, 13'd50}));
    tick(1);
    check("step0_e1_done", 32'({done, busy}), 32'({1'b1, 1'b0}));
    check("step0_e1_freq", 32'(freq), 50);

    // Start above stop, mask 0 treated as sine only.
    cfg(200, 100, 10, 1, 4'b0000, 1'b0);
    do_start();
    check("inv_e0", 32'({waveform_sel, freq}), 32'({2'd0, 13'd200}));
    tick(1);
    check("inv_e1_done", 32'(done), 1);

    // Near top of range: sum would exceed f_stop, no wrap.
    cfg(8190, 8191, 5, 2, 4'b0001, 1'b0);
    do_start();
    check("wrap_e0", 32'(freq), 8190);
    tick(1);
    check("wrap_e1", 32'({busy, done, freq}), 32'({1'b1, 1'b0, 13'd8190}));
    tick(1);
    check("wrap_e2", 32'({busy, done, freq}), 32'({1'b0, 1'b1, 13'd8190}));

    // start with stop in IDLE stays idle.
    stop = 1'b1;
    do_start();
    stop = 1'b0;
    check("startstop_busy", 32'(busy), 0);

    // Hold stretches the first point to D+3 cycles.
    cfg(100, 130, 10, 4, 4'b0001, 1'b0);
    do_start();
    tick(1);
    hold = 1'b1;
    tick(3);
    hold = 1'b0;
    tick(2);
    check("hold_e6_freq", 32'(freq), 100);
    check("hold_e6_step", 32'(step_pulse), 0);
    tick(1);
    check("hold_e7_freq", 32'(freq), 110);
    check("hold_e7_step", 32'(step_pulse), 1);

    // Asynchronous reset mid-sweep, then a fresh sweep.
    tick(2);
    #2 reset = 1'b1;
    #1;
    check("amid_rst_freq", 32'(freq), 0);
    check("amid_rst_busy", 32'(busy), 0);
    tick(1);
    #2 reset = 1'b0;
    cfg(300, 320, 20, 2, 4'b0100, 1'b0);
    do_start();
    check("post_rst_start", 32'({busy, waveform_sel, freq}), 32'({1'b1, 2'd2, 13'd300}));
    tick(2);
    check("post_rst_step", 32'(freq), 320);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
